cpu_sequencer: RTL and testbench

- Multi-cycle fetch/execute controller for the 16-bit core.
- Acts as the initiator of the register-file port set: drives read addresses, write port and PC count-enable, and consumes readData1/readData2/programCounter.
- Also masters the memory bus (req/ack handshake) for instruction fetch, load and store; the ALU stays external.

---
 rtl/cpu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 16-bit core: drives the register file ports and masters the memory bus.
// Optional single-step mode: define CPU_SEQUENCER_STEP_EN to add the step input.
module cpu_sequencer #(
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned NumRegs    = 8,
  parameter int unsigned IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CPU_SEQUENCER_STEP_EN
  input  logic                  step,
`endif
  output logic                  countEnable,
  output logic                  writeEnable,
  output logic [IndexWidth-1:0] writeAddr,
  output logic [DataWidth-1:0]  writeData,
  output logic [IndexWidth-1:0] readAddr1,
  output logic [IndexWidth-1:0] readAddr2,
  input  logic [DataWidth-1:0]  readData1,
  input  logic [DataWidth-1:0]  readData2,
  input  logic [DataWidth-1:0]  programCounter,
  output logic [2:0]            aluOp,
  input  logic [DataWidth-1:0]  aluResult,
  output logic                  memReq,
  output logic                  memWe,
  output logic [DataWidth-1:0]  memAddr,
  output logic [DataWidth-1:0]  memWData,
  input  logic                  memAck,
  input  logic [DataWidth-1:0]  memRData,
  output logic                  halted,
  output logic                  illegal
);

  localparam int unsigned ImmWidth = 9;
  localparam logic [3:0]  OpNop    = 4'h0;
  localparam logic [3:0]  OpLdi    = 4'h8;
  localparam logic [3:0]  OpLd     = 4'h9;
  localparam logic [3:0]  OpSt     = 4'hA;
  localparam logic [3:0]  OpJnz    = 4'hB;
  localparam logic [3:0]  OpHalt   = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [DataWidth-1:0] instr;
  logic [3:0]           op;
  logic [2:0]           rd;
  logic                 instr_load;
  logic                 req_fetch;

  assign op        = instr[15:12];
  assign rd        = instr[11:9];
  assign readAddr1 = IndexWidth'(instr[8:6]);
  assign readAddr2 = IndexWidth'(instr[5:3]);
  assign aluOp     = instr[14:12];

`ifdef CPU_SEQUENCER_STEP_EN
  // A fetch request started by a step pulse stays up until it is acknowledged.
  logic req_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_hold <= 1'b0;
    end else begin
      req_hold <= (state == FETCH) && req_fetch && !memAck;
    end
  end

  assign req_fetch = step | req_hold;
`else
  assign req_fetch = 1'b1;
`endif

  // State and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      instr <= '0;
    end else begin
      state <= state_next;
      if (instr_load) begin
        instr <= memRData;
      end
    end
  end

  // Next state and bus/register-file strobes; everything is held low while rst is asserted
  always_comb begin
    state_next  = state;
    instr_load  = 1'b0;
    countEnable = 1'b0;
    writeEnable = 1'b0;
    writeAddr   = '0;
    writeData   = '0;
    memReq      = 1'b0;
    memWe       = 1'b0;
    memAddr     = '0;
    memWData    = '0;
    halted      = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          if (req_fetch) begin
            memReq  = 1'b1;
            memAddr = programCounter;
            if (memAck) begin
              instr_load  = 1'b1;
              countEnable = 1'b1;
              state_next  = EXEC;
            end
          end
        end
        EXEC: begin
          state_next = FETCH;
          case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
              writeEnable = 1'b1;
              writeAddr   = IndexWidth'(rd);
              writeData   = aluResult;
            end
            OpLdi: begin
              writeEnable = 1'b1;
              writeAddr   = IndexWidth'(rd);
              writeData   = {{(DataWidth - ImmWidth){instr[ImmWidth-1]}}, instr[ImmWidth-1:0]};
            end
            OpJnz: begin
              if (readData1 != '0) begin
                writeEnable = 1'b1;
                writeAddr   = IndexWidth'(NumRegs - 1);
                writeData   = readData2;
              end
            end
            OpLd, OpSt: state_next = MEM;
            OpHalt:     state_next = HALT;
            OpNop:      state_next = FETCH;
            default:    illegal    = 1'b1;
          endcase
        end
        MEM: begin
          memReq  = 1'b1;
          memAddr = readData1;
          if (op == OpSt) begin
            memWe    = 1'b1;
            memWData = readData2;
          end
          if (memAck) begin
            state_next = FETCH;
            if (op == OpLd) begin
              writeEnable = 1'b1;
              writeAddr   = IndexWidth'(rd);
              writeData   = memRData;
            end
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer with a behavioural register file, ALU and variable-latency memory.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
`ifdef CPU_SEQUENCER_STEP_EN
  logic        step = 1'b1;
`endif
  logic        countEnable, writeEnable, memReq, memWe, memAck, halted, illegal;
  logic [2:0]  writeAddr, readAddr1, readAddr2, aluOp;
  logic [15:0] writeData, readData1, readData2, programCounter, aluResult;
  logic [15:0] memAddr, memWData, memRData;

  logic [15:0] regs [8];
  logic [15:0] init_regs [8];
  logic        load_regs = 1'b0;
  logic [15:0] mem [256];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [15:0] st_addr, st_data;
  int          st_count = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef CPU_SEQUENCER_STEP_EN
    .step(step),
`endif
    .countEnable(countEnable), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeData(writeData), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(readData1), .readData2(readData2), .programCounter(programCounter),
    .aluOp(aluOp), .aluResult(aluResult), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData), .memAck(memAck), .memRData(memRData),
    .halted(halted), .illegal(illegal)
  );

  // Register file: r0 reads zero, r7 is the PC
  assign readData1      = (readAddr1 == 3'd0) ? 16'h0 : regs[readAddr1];
  assign readData2      = (readAddr2 == 3'd0) ? 16'h0 : regs[readAddr2];
  assign programCounter = regs[7];
  assign aluResult      = (aluOp == 3'd1) ? readData1 + readData2 : readData1 ^ readData2;

  always @(posedge clk) begin
    if (load_regs) begin
      for (int i = 0; i < 8; i++) regs[i] <= init_regs[i];
    end else begin
      if (writeEnable && writeAddr != 3'd0) regs[writeAddr] <= writeData;
      if (countEnable) regs[7] <= regs[7] + 16'd1;
    end
  end

  // Memory: acknowledges after ack_delay cycles of continuous request
  assign memAck   = memReq && (wait_cnt >= ack_delay);
  assign memRData = memReq ? mem[memAddr[7:0]] : 16'h0;

  always @(posedge clk) begin
    if (rst || !memReq || memAck) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (load_regs) st_count <= 0;
    else if (memReq && memWe && memAck) begin
      st_addr  <= memAddr;
      st_data  <= memWData;
      st_count <= st_count + 1;
    end
  end

  task automatic clear_env();
    for (int i = 0; i < 8; i++) init_regs[i] = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    ack_delay = 0;
  endtask

  // Hold reset across one edge (loading the register file), release at negedge; returns in cycle 1
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load_regs = 1'b1;
    @(negedge clk);
    load_regs = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_env();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL rst_memReq got=%h exp=0", memReq); end
    checks++; if (countEnable !== 1'b0 || writeEnable !== 1'b0) begin failures++; $display("FAIL rst_strobes got=%b%b exp=00", countEnable, writeEnable); end
    checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_status got=%b%b exp=00", halted, illegal); end
    checks++; if (readAddr1 !== 3'd0 || readAddr2 !== 3'd0 || aluOp !== 3'd0) begin failures++; $display("FAIL rst_instr_fields got=%h/%h/%h exp=0/0/0", readAddr1, readAddr2, aluOp); end
    checks++; if (memAddr !== 16'h0 || writeData !== 16'h0) begin failures++; $display("FAIL rst_buses got=%h/%h exp=0000/0000", memAddr, writeData); end
  endtask

  task automatic test_ldi();
    clear_env();
    mem[0] = 16'h8205;
    do_reset();
    checks++; if (memReq !== 1'b1 || memAddr !== 16'h0000) begin failures++; $display("FAIL ldi_fetch got=%b/%h exp=1/0000", memReq, memAddr); end
    checks++; if (countEnable !== 1'b1 || writeEnable !== 1'b0) begin failures++; $display("FAIL ldi_c1_count got=%b%b exp=10", countEnable, writeEnable); end
    next();
    checks++; if (writeEnable !== 1'b1 || writeAddr !== 3'd1 || writeData !== 16'h0005) begin failures++; $display("FAIL ldi_write got=%b/%h/%h exp=1/1/0005", writeEnable, writeAddr, writeData); end
    checks++; if (countEnable !== 1'b0 || memReq !== 1'b0) begin failures++; $display("FAIL ldi_exec_idle got=%b%b exp=00", countEnable, memReq); end
    checks++; if (programCounter !== 16'h0001) begin failures++; $display("FAIL ldi_pc got=%h exp=0001", programCounter); end
    next();
    checks++; if (memAddr !== 16'h0001 || regs[1] !== 16'h0005) begin failures++; $display("FAIL ldi_next got=%h/%h exp=0001/0005", memAddr, regs[1]); end
  endtask

  task automatic test_ldi_sign();
    clear_env();
    mem[0] = 16'h85FF;
    do_reset();
    next();
    checks++; if (writeEnable !== 1'b1 || writeAddr !== 3'd2 || writeData !== 16'hFFFF) begin failures++; $display("FAIL ldi_sext got=%b/%h/%h exp=1/2/ffff", writeEnable, writeAddr, writeData); end
  endtask

  task automatic test_alu();
    clear_env();
    init_regs[1] = 16'h0005;
    init_regs[2] = 16'h0007;
    mem[0] = 16'h1650;
    do_reset();
    next();
    checks++; if (aluOp !== 3'd1 || readAddr1 !== 3'd1 || readAddr2 !== 3'd2) begin failures++; $display("FAIL alu_fields got=%h/%h/%h exp=1/1/2", aluOp, readAddr1, readAddr2); end
    checks++; if (writeEnable !== 1'b1 || writeAddr !== 3'd3 || writeData !== 16'h000C) begin failures++; $display("FAIL alu_write got=%b/%h/%h exp=1/3/000c", writeEnable, writeAddr, writeData); end
  endtask

  task automatic test_ld_wait();
    clear_env();
    init_regs[3] = 16'h0040;
    mem[8'h40] = 16'hBEEF;
    mem[0] = 16'h98C0;
    do_reset();
    next();
    checks++; if (writeEnable !== 1'b0 || memReq !== 1'b0) begin failures++; $display("FAIL ld_exec got=%b%b exp=00", writeEnable, memReq); end
    ack_delay = 3;
    for (int i = 0; i < 4; i++) begin
      next();
      checks++; if (memReq !== 1'b1 || memAddr !== 16'h0040 || memWe !== 1'b0) begin failures++; $display("FAIL ld_hold%0d got=%b/%h/%b exp=1/0040/0", i, memReq, memAddr, memWe); end
      checks++; if (countEnable !== 1'b0 || writeEnable !== (i == 3)) begin failures++; $display("FAIL ld_strobe%0d got=%b%b exp=0%b", i, countEnable, writeEnable, i == 3); end
    end
    checks++; if (writeAddr !== 3'd4 || writeData !== 16'hBEEF) begin failures++; $display("FAIL ld_data got=%h/%h exp=4/beef", writeAddr, writeData); end
    ack_delay = 0;
    next();
    checks++; if (memAddr !== 16'h0001 || regs[4] !== 16'hBEEF) begin failures++; $display("FAIL ld_after got=%h/%h exp=0001/beef", memAddr, regs[4]); end
  endtask

  task automatic test_st();
    clear_env();
    init_regs[3] = 16'h0040;
    init_regs[5] = 16'h1234;
    mem[0] = 16'hA0E8;
    do_reset();
    next();
    next();
    checks++; if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 16'h0040 || memWData !== 16'h1234) begin failures++; $display("FAIL st_bus got=%b%b/%h/%h exp=11/0040/1234", memReq, memWe, memAddr, memWData); end
    checks++; if (writeEnable !== 1'b0 || countEnable !== 1'b0) begin failures++; $display("FAIL st_strobes got=%b%b exp=00", writeEnable, countEnable); end
    next();
    checks++; if (st_count !== 1 || st_addr !== 16'h0040 || st_data !== 16'h1234) begin failures++; $display("FAIL st_stored got=%0d/%h/%h exp=1/0040/1234", st_count, st_addr, st_data); end
    checks++; if (memAddr !== 16'h0001 || memWe !== 1'b0) begin failures++; $display("FAIL st_next got=%h/%b exp=0001/0", memAddr, memWe); end
  endtask

  task automatic test_jnz();
    clear_env();
    init_regs[1] = 16'h0001;
    init_regs[2] = 16'h0010;
    mem[0] = 16'hB050;
    do_reset();
    next();
    checks++; if (writeEnable !== 1'b1 || writeAddr !== 3'd7 || writeData !== 16'h0010 || countEnable !== 1'b0) begin failures++; $display("FAIL jnz_taken got=%b/%h/%h/%b exp=1/7/0010/0", writeEnable, writeAddr, writeData, countEnable); end
    next();
    checks++; if (memReq !== 1'b1 || memAddr !== 16'h0010) begin failures++; $display("FAIL jnz_target got=%b/%h exp=1/0010", memReq, memAddr); end
    clear_env();
    init_regs[2] = 16'h0010;
    mem[0] = 16'hB010;
    do_reset();
    next();
    checks++; if (writeEnable !== 1'b0) begin failures++; $display("FAIL jnz_not_taken got=%b exp=0", writeEnable); end
    next();
    checks++; if (memAddr !== 16'h0001) begin failures++; $display("FAIL jnz_fallthrough got=%h exp=0001", memAddr); end
  endtask

  task automatic test_illegal_halt();
    clear_env();
    mem[0] = 16'hD000;
    mem[1] = 16'hF000;
    do_reset();
    next();
    checks++; if (illegal !== 1'b1 || writeEnable !== 1'b0) begin failures++; $display("FAIL illegal_pulse got=%b%b exp=10", illegal, writeEnable); end
    next();
    checks++; if (illegal !== 1'b0 || memReq !== 1'b1 || memAddr !== 16'h0001) begin failures++; $display("FAIL illegal_end got=%b/%b/%h exp=0/1/0001", illegal, memReq, memAddr); end
    next();
    checks++; if (halted !== 1'b0 || memReq !== 1'b0 || writeEnable !== 1'b0) begin failures++; $display("FAIL halt_exec got=%b%b%b exp=000", halted, memReq, writeEnable); end
    for (int i = 0; i < 20; i++) begin
      next();
      checks++; if (halted !== 1'b1 || memReq !== 1'b0 || writeEnable !== 1'b0 || countEnable !== 1'b0) begin failures++; $display("FAIL halt_hold%0d got=%b%b%b%b exp=1000", i, halted, memReq, writeEnable, countEnable); end
    end
  endtask

  task automatic test_reset_mid();
    clear_env();
    mem[0] = 16'h8205;
    ack_delay = 10;
    do_reset();
    checks++; if (memReq !== 1'b1 || countEnable !== 1'b0) begin failures++; $display("FAIL midrst_wait got=%b%b exp=10", memReq, countEnable); end
    next();
    next();
    rst = 1'b1;
    #1;
    checks++; if (memReq !== 1'b0 || memAddr !== 16'h0000) begin failures++; $display("FAIL midrst_drop got=%b/%h exp=0/0000", memReq, memAddr); end
    ack_delay = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (memReq !== 1'b1 || memAddr !== 16'h0000 || countEnable !== 1'b1) begin failures++; $display("FAIL midrst_restart got=%b/%h/%b exp=1/0000/1", memReq, memAddr, countEnable); end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_ldi_sign();
    test_alu();
    test_ld_wait();
    test_st();
    test_jnz();
    test_illegal_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
